// File: rtl/encode_pack.sv
// MSB-first variable-length code packer with output word FIFO and end-of-stream flush.
// Define ENCODE_PACK_ENDMARK_EN to append the LZS end marker (110000000) before padding.
module encode_pack #(
  parameter int OUT_W    = 16,
  parameter int MAX_CODE = 13,
  parameter int LEN_W    = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                code_valid,
  input  logic [MAX_CODE-1:0] code_data,
  input  logic [LEN_W-1:0]    code_len,
  input  logic                code_finish,
  output logic                code_ready,
  input  logic                fo_full,
  output logic [OUT_W-1:0]    data_o,
  output logic                valid_o,
  output logic                done_o,
  output logic [15:0]         word_cnt
);

  localparam int ACC_W = OUT_W + MAX_CODE;
  localparam int FW    = $clog2(ACC_W) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [FW-1:0]     ACC_F   = FW'(ACC_W);
  localparam logic [FW-1:0]     OUT_F   = FW'(OUT_W);
  localparam logic [LEN_W-1:0]  MAX_L   = LEN_W'(MAX_CODE);
  localparam logic [MAX_CODE:0] ONE_M   = (MAX_CODE+1)'(1);
  localparam logic [AW:0]       PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_RUN,
    S_PAD,
    S_DRAIN
`ifdef ENCODE_PACK_ENDMARK_EN
    , S_MARK
`endif
  } state_t;

  state_t state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, acc_base, code_wide;
  logic [FW-1:0] fill, fill_nx, fill_base, len_f, code_sh;
  logic [LEN_W-1:0] len_sat;
  logic [MAX_CODE:0] len_mask;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic fifo_full, fifo_empty, push_ok, push, pop, accept, fin_acc, done_nx;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = (fill >= OUT_F) && !fifo_full;
  assign pop        = ce && !fo_full && !fifo_empty;
  assign code_ready = (state == S_RUN) && ((fill < OUT_F) || push_ok);
  assign accept     = ce && code_valid && code_ready;
  assign fin_acc    = ce && code_finish && code_ready;

  // A code lands directly behind whatever survives this cycle's word push.
  assign len_sat   = (code_len > MAX_L) ? MAX_L : code_len;
  assign len_f     = FW'(len_sat);
  assign len_mask  = (ONE_M << len_sat) - ONE_M;
  assign acc_base  = push_ok ? (acc << OUT_W) : acc;
  assign fill_base = push_ok ? (fill - OUT_F) : fill;
  assign code_sh   = ACC_F - fill_base - len_f;
  assign code_wide = ACC_W'(code_data & len_mask[MAX_CODE-1:0]) << code_sh;

`ifdef ENCODE_PACK_ENDMARK_EN
  localparam logic [8:0] END_MARK = 9'b110000000;
  logic [ACC_W-1:0] mark_wide;
  assign mark_wide = ACC_W'(END_MARK) << (ACC_F - fill - FW'(9));
`endif

  always_comb begin
    state_nx = state;
    acc_nx   = acc_base;
    fill_nx  = fill_base;
    push     = push_ok;
    done_nx  = 1'b0;
    case (state)
      S_RUN: begin
        if (accept) begin
          acc_nx  = acc_base | code_wide;
          fill_nx = fill_base + len_f;
        end
`ifdef ENCODE_PACK_ENDMARK_EN
        if (fin_acc) state_nx = S_MARK;
`else
        if (fin_acc) state_nx = S_PAD;
`endif
      end
`ifdef ENCODE_PACK_ENDMARK_EN
      S_MARK: begin
        if (fill < OUT_F) begin
          acc_nx   = acc | mark_wide;
          fill_nx  = fill + FW'(9);
          state_nx = S_PAD;
        end
      end
`endif
      S_PAD: begin
        // Lower accumulator bits are always zero, so the top word is already padded.
        if (fill == '0) begin
          state_nx = S_DRAIN;
        end else if ((fill < OUT_F) && !fifo_full) begin
          push    = 1'b1;
          acc_nx  = '0;
          fill_nx = '0;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done_nx  = 1'b1;
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      acc      <= '0;
      fill     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      done_o   <= 1'b0;
      word_cnt <= '0;
    end else if (ce) begin
      state   <= state_nx;
      acc     <= acc_nx;
      fill    <= fill_nx;
      valid_o <= pop;
      done_o  <= done_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data_o <= mem[rd_ptr[AW-1:0]];
      end
      if (done_nx) word_cnt <= '0;
      else if (pop) word_cnt <= word_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ce && push) mem[wr_ptr[AW-1:0]] <= acc[ACC_W-1 -: OUT_W];
  end

endmodule
